// File: rtl/bcd_pkg.sv
// Shared types, constants and the digit decode helper for the BCD scanner.
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam int DEC_W = 10;

    localparam logic [DEC_W-1:0] DEC_ALL_ONES = 10'h3FF;
    localparam logic [DEC_W-1:0] DEC_BLANK    = 10'h000;

    typedef enum logic {
        INV_ONES  = 1'b0,
        INV_ZEROS = 1'b1
    } inv_mode_e;

    function automatic logic [DEC_W-1:0] bcd_onehot(
        input logic [BCD_W-1:0] d,
        input inv_mode_e        mode
    );
        if (d > 4'd9) begin
            return (mode == INV_ZEROS) ? DEC_BLANK : DEC_ALL_ONES;
        end
        return DEC_W'(1) << d;
    endfunction

endpackage

// File: rtl/bcd_onehot_dec.sv
// Single-digit BCD to one-hot decimal decoder with invalid-code flag.
module bcd_onehot_dec
    import bcd_pkg::*;
#(
    parameter int INVALID_MODE = 0
) (
    input  logic [BCD_W-1:0] digit,
    output logic [DEC_W-1:0] code,
    output logic             invalid
);

    localparam inv_mode_e MODE = (INVALID_MODE != 0) ? INV_ZEROS : INV_ONES;

    assign code    = bcd_onehot(digit, MODE);
    assign invalid = (digit > 4'd9);

endmodule

// File: rtl/bcd_decimal_scanner.sv
// Time-multiplexed BCD display driver: shadow-buffered word, per-digit dwell
// scan, registered one-hot decimal code and digit select.
module bcd_decimal_scanner
    import bcd_pkg::*;
#(
    parameter  int NUM_DIGITS   = 4,
    parameter  int DWELL_CYCLES = 4,
    parameter  int INVALID_MODE = 0,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                        Clk,
    input  logic                        ResetN,
    input  logic                        Enable,
    input  logic                        LoadValid,
    output logic                        LoadReady,
    input  logic [BCD_W*NUM_DIGITS-1:0] BCDIn,
    input  logic                        ErrClr,
    output logic [DEC_W-1:0]            DECOut,
    output logic [NUM_DIGITS-1:0]       DigitSel,
    output logic [IDX_W-1:0]            DigitIdx,
    output logic                        FrameDone,
    output logic                        InvalidDigit,
    output logic                        ErrSticky
);

    localparam int WORD_W = BCD_W * NUM_DIGITS;
    localparam int DW_W   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    logic [WORD_W-1:0] shadow;
    logic [WORD_W-1:0] display_reg;
    logic [WORD_W-1:0] src_word;
    logic              shadow_vld;
    logic [IDX_W-1:0]  idx;
    logic [DW_W-1:0]   dwell;
    logic              accept;
    logic              transfer;
    logic              last_dwell;
    logic              last_digit;
    logic [BCD_W-1:0]  cur_digit;
    logic [DEC_W-1:0]  cur_code;
    logic              cur_inv;

    assign LoadReady  = ~shadow_vld;
    assign accept     = LoadValid & ~shadow_vld;
    assign transfer   = shadow_vld & (FrameDone | ~Enable);
    assign last_dwell = (dwell == DW_W'(DWELL_CYCLES - 1));
    assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));

    // The first digit of a new frame is latched on the same edge as the
    // shadow transfer, so decode from the incoming word on that edge.
    assign src_word  = transfer ? shadow : display_reg;
    assign cur_digit = src_word[idx*BCD_W +: BCD_W];

    bcd_onehot_dec #(
        .INVALID_MODE(INVALID_MODE)
    ) u_dec (
        .digit  (cur_digit),
        .code   (cur_code),
        .invalid(cur_inv)
    );

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            shadow      <= '0;
            shadow_vld  <= 1'b0;
            display_reg <= '0;
        end else begin
            if (transfer) begin
                display_reg <= shadow;
                shadow_vld  <= 1'b0;
            end
            if (accept) begin
                shadow     <= BCDIn;
                shadow_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            idx          <= '0;
            dwell        <= '0;
            DECOut       <= DEC_BLANK;
            DigitSel     <= '0;
            DigitIdx     <= '0;
            FrameDone    <= 1'b0;
            InvalidDigit <= 1'b0;
        end else if (!Enable) begin
            idx          <= '0;
            dwell        <= '0;
            DECOut       <= DEC_BLANK;
            DigitSel     <= '0;
            DigitIdx     <= '0;
            FrameDone    <= 1'b0;
            InvalidDigit <= 1'b0;
        end else begin
            DECOut       <= cur_code;
            DigitSel     <= NUM_DIGITS'(1) << idx;
            DigitIdx     <= idx;
            FrameDone    <= last_digit & last_dwell;
            InvalidDigit <= cur_inv;
            if (last_dwell) begin
                dwell <= '0;
                idx   <= last_digit ? '0 : idx + IDX_W'(1);
            end else begin
                dwell <= dwell + DW_W'(1);
            end
        end
    end

    // Rises together with InvalidDigit; a clear during a displayed
    // invalid digit loses against the set.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            ErrSticky <= 1'b0;
        end else begin
            ErrSticky <= (Enable & cur_inv) | InvalidDigit
                       | (ErrSticky & ~ErrClr);
        end
    end

endmodule

// File: tb/tb_bcd_decimal_scanner.sv
// Bench: table vectors, directed corner sequences and random stimulus
// against a position-based reference model, on two configurations.
module tb_bcd_decimal_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        lv = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] bcd = '0;

    logic [9:0]  a_dec, b_dec;
    logic [3:0]  a_sel;
    logic [1:0]  a_idx;
    logic [0:0]  b_sel, b_idx;
    logic        a_fd, a_inv, a_err, a_rdy;
    logic        b_fd, b_inv, b_err, b_rdy;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcd_decimal_scanner #(
        .NUM_DIGITS(4), .DWELL_CYCLES(2), .INVALID_MODE(0)
    ) ua (
        .Clk(clk), .ResetN(rst_n), .Enable(en), .LoadValid(lv),
        .LoadReady(a_rdy), .BCDIn(bcd), .ErrClr(clr),
        .DECOut(a_dec), .DigitSel(a_sel), .DigitIdx(a_idx),
        .FrameDone(a_fd), .InvalidDigit(a_inv), .ErrSticky(a_err)
    );

    bcd_decimal_scanner #(
        .NUM_DIGITS(1), .DWELL_CYCLES(1), .INVALID_MODE(1)
    ) ub (
        .Clk(clk), .ResetN(rst_n), .Enable(en), .LoadValid(lv),
        .LoadReady(b_rdy), .BCDIn(bcd[3:0]), .ErrClr(clr),
        .DECOut(b_dec), .DigitSel(b_sel), .DigitIdx(b_idx),
        .FrameDone(b_fd), .InvalidDigit(b_inv), .ErrSticky(b_err)
    );

    typedef struct packed {
        bit [31:0] run;
        bit [15:0] disp;
        bit [15:0] shad;
        bit        full;
        bit        fd;
        bit        inv;
        bit        err;
    } mstate_t;

    typedef struct packed {
        bit [9:0] dec;
        bit [3:0] sel;
        bit [1:0] idx;
        bit       fd;
        bit       inv;
        bit       err;
        bit       rdy;
    } exp_t;

    typedef struct {
        bit        en;
        bit        lv;
        bit [15:0] bcd;
        bit [3:0]  sel;
        bit [9:0]  dec;
        bit        fd;
    } vec_t;

    mstate_t sa, sb, sn;
    exp_t    ea, eb;
    vec_t    tbl[10];

    // run = number of consecutive enabled edges; digit and dwell follow
    // from it by division, independent of any counter structure.
    function automatic void mstep(
        input int n, input int d, input int mode,
        input bit e_, input bit l_, input bit c_, input bit [15:0] b_,
        input mstate_t s, output mstate_t ns, output exp_t e
    );
        int pos, dg, dw, v;
        bit xfer;
        bit [15:0] src;
        ns = s;
        e = '0;
        xfer = s.full && (s.fd || !e_);
        src = xfer ? s.shad : s.disp;
        if (e_) begin
            pos = int'(s.run);
            dg = (pos / d) % n;
            dw = pos % d;
            v = int'((src >> (4 * dg)) & 16'hF);
            if (v <= 9) e.dec = 10'(1 << v);
            else e.dec = (mode != 0) ? 10'h000 : 10'h3FF;
            e.sel = 4'(1 << dg);
            e.idx = 2'(dg);
            e.fd = (dg == n - 1) && (dw == d - 1);
            e.inv = (v > 9);
            ns.run = s.run + 1;
        end else begin
            ns.run = 0;
        end
        e.err = e.inv | s.inv | (s.err & !c_);
        ns.disp = src;
        if (xfer) ns.full = 1'b0;
        if (l_ && !s.full) begin
            ns.shad = b_;
            ns.full = 1'b1;
        end
        ns.fd = e.fd;
        ns.inv = e.inv;
        ns.err = e.err;
        e.rdy = !ns.full;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, expv, $time);
        end
    endtask

    task automatic cmp_all();
        chk("a.DECOut", 32'(a_dec), 32'(ea.dec));
        chk("a.DigitSel", 32'(a_sel), 32'(ea.sel));
        chk("a.DigitIdx", 32'(a_idx), 32'(ea.idx));
        chk("a.FrameDone", 32'(a_fd), 32'(ea.fd));
        chk("a.InvalidDigit", 32'(a_inv), 32'(ea.inv));
        chk("a.ErrSticky", 32'(a_err), 32'(ea.err));
        chk("a.LoadReady", 32'(a_rdy), 32'(ea.rdy));
        chk("b.DECOut", 32'(b_dec), 32'(eb.dec));
        chk("b.DigitSel", 32'(b_sel), 32'(eb.sel));
        chk("b.DigitIdx", 32'(b_idx), 32'(eb.idx));
        chk("b.FrameDone", 32'(b_fd), 32'(eb.fd));
        chk("b.InvalidDigit", 32'(b_inv), 32'(eb.inv));
        chk("b.ErrSticky", 32'(b_err), 32'(eb.err));
        chk("b.LoadReady", 32'(b_rdy), 32'(eb.rdy));
    endtask

    task automatic cyc(input bit e_, input bit l_, input bit [15:0] b_,
                       input bit c_);
        en = e_;
        lv = l_;
        bcd = b_;
        clr = c_;
        @(posedge clk);
        mstep(4, 2, 0, e_, l_, c_, b_, sa, sn, ea);
        sa = sn;
        mstep(1, 1, 1, e_, l_, c_, b_, sb, sn, eb);
        sb = sn;
        @(negedge clk);
        cmp_all();
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        #2;
        chk("rst.DECOut", 32'(a_dec), 0);
        chk("rst.DigitSel", 32'(a_sel), 0);
        chk("rst.DigitIdx", 32'(a_idx), 0);
        chk("rst.FrameDone", 32'(a_fd), 0);
        chk("rst.InvalidDigit", 32'(a_inv), 0);
        chk("rst.ErrSticky", 32'(a_err), 0);
        chk("rst.LoadReady", 32'(a_rdy), 1);
        chk("rst.b.LoadReady", 32'(b_rdy), 1);
        sa = '0;
        sb = '0;
        en = 1'b0;
        lv = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        bit found;
        bit [15:0] rb;

        tbl[0] = '{1'b0, 1'b1, 16'h1234, 4'b0000, 10'h000, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 16'h0000, 4'b0000, 10'h000, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 16'h0000, 4'b0001, 10'b0000010000, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 16'h0000, 4'b0001, 10'b0000010000, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 16'h0000, 4'b0010, 10'b0000001000, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 16'h0000, 4'b0010, 10'b0000001000, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 16'h0000, 4'b0100, 10'b0000000100, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 16'h0000, 4'b0100, 10'b0000000100, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 16'h0000, 4'b1000, 10'b0000000010, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 16'h0000, 4'b1000, 10'b0000000010, 1'b1};

        hard_reset();

        // Test 1: table, applied twice to see the pattern repeat
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 10; i++) begin
                cyc(tbl[i].en, tbl[i].lv, tbl[i].bcd, 1'b0);
                chk("t1.DigitSel", 32'(a_sel), 32'(tbl[i].sel));
                chk("t1.DECOut", 32'(a_dec), 32'(tbl[i].dec));
                chk("t1.FrameDone", 32'(a_fd), 32'(tbl[i].fd));
            end
        end

        // Test 2: back-to-back loads, second held until the boundary
        cyc(1'b1, 1'b1, 16'h0000, 1'b0);
        chk("t2.ready_after_load", 32'(a_rdy), 0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 16'h9999, 1'b0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 16'h0000, 1'b0);
            chk("t2.nines", 32'(a_dec), 32'h200);
        end

        // Test 3: invalid digit 1, sticky error and clear
        cyc(1'b1, 1'b1, 16'h00A0, 1'b0);
        for (int i = 0; i < 24; i++) cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 16'h0000, 1'b0);
            if (a_inv) begin
                cnt++;
                chk("t3.inv_code", 32'(a_dec), 32'h3FF);
                chk("t3.inv_sel", 32'(a_sel), 32'b0010);
            end
        end
        chk("t3.inv_count", 32'(cnt), 2);
        chk("t3.sticky", 32'(a_err), 1);
        cyc(1'b1, 1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < 24; i++) cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("t3.sticky_held", 32'(a_err), 1);
        cyc(1'b1, 1'b0, 16'h0000, 1'b1);
        chk("t3.cleared", 32'(a_err), 0);

        // Test 4: drop Enable at digit 2, then restart
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            cyc(1'b1, 1'b0, 16'h0000, 1'b0);
            found = (a_idx == 2'd2);
        end
        chk("t4.reached_idx2", 32'(found), 1);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("t4.dec_blank", 32'(a_dec), 0);
        chk("t4.sel_blank", 32'(a_sel), 0);
        chk("t4.idx_zero", 32'(a_idx), 0);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("t4.restart0", 32'(a_sel), 32'b0001);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("t4.dwell_full", 32'(a_sel), 32'b0001);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("t4.next_digit", 32'(a_sel), 32'b0010);

        // Test 5: reset mid-frame with the shadow full
        cyc(1'b1, 1'b1, 16'h5678, 1'b0);
        chk("t5.shadow_full", 32'(a_rdy), 0);
        hard_reset();
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("t5.digit0_zero", 32'(a_dec), 32'h001);

        // Test 6: single digit, single dwell, two-cycle load latency
        cyc(1'b1, 1'b1, 16'h0005, 1'b0);
        chk("t6.still_old", 32'(b_dec), 32'h001);
        chk("t6.fd", 32'(b_fd), 1);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("t6.shown_t2", 32'(b_dec), 32'h020);
        chk("t6.fd2", 32'(b_fd), 1);
        chk("t6.sel", 32'(b_sel), 1);
        cyc(1'b1, 1'b1, 16'h000C, 1'b0);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        chk("t6.mode1_zero", 32'(b_dec), 0);
        chk("t6.mode1_inv", 32'(b_inv), 1);

        // Random stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 4; k++)
                rb[4*k +: 4] = 4'($urandom_range(0, 11));
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
                rb, $urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
